// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: owner and FSM encodings, source indices
// and the load/store type widths used across the memory subsystem.
package mem_arbiter_pkg;

    localparam int LOAD_TYPE_NUM_WIDTH  = 3;
    localparam int STORE_TYPE_NUM_WIDTH = 2;

    localparam int NUM_SRC = 3;
    localparam int SRC_IC  = 0;
    localparam int SRC_LSB = 1;
    localparam int SRC_ROB = 2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IC   = 2'd1,
        OWN_LSB  = 2'd2,
        OWN_ROB  = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    function automatic owner_e src_owner(input int idx);
        case (idx)
            SRC_IC:  return OWN_IC;
            SRC_LSB: return OWN_LSB;
            SRC_ROB: return OWN_ROB;
            default: return OWN_NONE;
        endcase
    endfunction

    function automatic owner_e grant_owner(input logic [NUM_SRC-1:0] grant);
        if (grant[SRC_ROB])      return OWN_ROB;
        else if (grant[SRC_LSB]) return OWN_LSB;
        else if (grant[SRC_IC])  return OWN_IC;
        else                     return OWN_NONE;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: store > load > fetch, with fetch forced
// through once the starvation counter reaches its limit.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int SW           = 3
) (
    input  logic [NUM_SRC-1:0] full,
    input  logic [SW-1:0]      starve_cnt,
    output logic [NUM_SRC-1:0] grant
);

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    always_comb begin
        grant = '0;
        if (full[SRC_IC] && (starve_cnt == STARVE_MAX)) begin
            grant[SRC_IC] = 1'b1;
        end else if (full[SRC_ROB]) begin
            grant[SRC_ROB] = 1'b1;
        end else if (full[SRC_LSB]) begin
            grant[SRC_LSB] = 1'b1;
        end else if (full[SRC_IC]) begin
            grant[SRC_IC] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache / LSB / RoB access to the byte-serial memory controller.
// Optional statistics counters and ports are enabled by MEM_ARB_STATS_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ROB_W        = 4,
    parameter int STARVE_LIMIT = 4
`ifdef MEM_ARB_STATS_EN
    , parameter int CNT_W      = 32
`endif
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            flush_in,
    input  logic                            ic_req,
    input  logic [31:0]                     ic_addr,
    output logic                            ic_ack,
    input  logic                            lsb_req,
    input  logic [31:0]                     lsb_addr,
    input  logic [ROB_W:0]                  lsb_dep,
    input  logic [LOAD_TYPE_NUM_WIDTH-1:0]  lsb_type,
    output logic                            lsb_ack,
    input  logic                            rob_req,
    input  logic [31:0]                     rob_addr,
    input  logic [31:0]                     rob_data,
    input  logic [STORE_TYPE_NUM_WIDTH-1:0] rob_type,
    output logic                            rob_ack,
    output logic                            rob_done,
    output logic                            mc_ic_valid,
    output logic                            mc_lsb_valid,
    output logic                            mc_rob_valid,
    output logic [31:0]                     mc_addr,
    output logic [31:0]                     mc_din,
    output logic [LOAD_TYPE_NUM_WIDTH-1:0]  mc_ld_type,
    output logic [STORE_TYPE_NUM_WIDTH-1:0] mc_st_type,
    output logic [ROB_W:0]                  mc_dep,
    input  logic                            mc_busy,
    input  logic                            mc_dout_ready,
    input  logic                            mc_iout_ready,
    output logic                            busy_out
`ifdef MEM_ARB_STATS_EN
    , output logic [CNT_W-1:0]              stat_ic_grants
    , output logic [CNT_W-1:0]              stat_ld_grants
    , output logic [CNT_W-1:0]              stat_st_grants
    , output logic [CNT_W-1:0]              stat_stall
    , output logic [CNT_W-1:0]              stat_killed
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_e state_reg, state_next;
    owner_e owner_reg, owner_next;
    logic   rob_done_reg, rob_done_next;
    logic [SW-1:0] starve_reg;

    logic [NUM_SRC-1:0] full_reg, ack_reg;
    logic [NUM_SRC-1:0] req_vec, kill_vec, clear_vec, accept_vec, full_eff, grant;

    logic [31:0]                     ic_addr_reg, lsb_addr_reg, rob_addr_reg, rob_data_reg;
    logic [ROB_W:0]                  lsb_dep_reg;
    logic [LOAD_TYPE_NUM_WIDTH-1:0]  lsb_type_reg;
    logic [STORE_TYPE_NUM_WIDTH-1:0] rob_type_reg;

    logic read_owner;

    assign read_owner = (owner_reg == OWN_IC) || (owner_reg == OWN_LSB);
    assign req_vec    = {rob_req, lsb_req, ic_req};
    // Flush kills both read slots but never the committed store.
    assign kill_vec   = {1'b0, flush_in, flush_in};
    assign full_eff   = full_reg & ~kill_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_slot
            assign clear_vec[gi]  = (state_reg == ST_ISSUE) && (owner_reg == src_owner(gi));
            assign accept_vec[gi] = req_vec[gi] && !full_reg[gi] && !ack_reg[gi] && !kill_vec[gi];

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    full_reg[gi] <= 1'b0;
                    ack_reg[gi]  <= 1'b0;
                end else if (rdy_in) begin
                    if (kill_vec[gi] || clear_vec[gi]) begin
                        full_reg[gi] <= 1'b0;
                        ack_reg[gi]  <= 1'b0;
                    end else if (accept_vec[gi]) begin
                        full_reg[gi] <= 1'b1;
                        ack_reg[gi]  <= 1'b1;
                    end else begin
                        ack_reg[gi]  <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ic_addr_reg  <= '0;
            lsb_addr_reg <= '0;
            lsb_dep_reg  <= '1;
            lsb_type_reg <= '0;
            rob_addr_reg <= '0;
            rob_data_reg <= '0;
            rob_type_reg <= '0;
        end else if (rdy_in) begin
            if (accept_vec[SRC_IC]) begin
                ic_addr_reg <= ic_addr;
            end
            if (accept_vec[SRC_LSB]) begin
                lsb_addr_reg <= lsb_addr;
                lsb_dep_reg  <= lsb_dep;
                lsb_type_reg <= lsb_type;
            end
            if (accept_vec[SRC_ROB]) begin
                rob_addr_reg <= rob_addr;
                rob_data_reg <= rob_data;
                rob_type_reg <= rob_type;
            end
        end
    end

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SW           (SW)
    ) u_pick (
        .full       (full_eff),
        .starve_cnt (starve_reg),
        .grant      (grant)
    );

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rob_done_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!mc_busy && (|full_eff)) begin
                    state_next = ST_ISSUE;
                    owner_next = grant_owner(grant);
                end
            end
            ST_ISSUE: begin
                if (flush_in && read_owner) begin
                    state_next = ST_IDLE;
                    owner_next = OWN_NONE;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                case (owner_reg)
                    OWN_IC: if (flush_in || mc_iout_ready) begin
                        state_next = ST_IDLE;
                        owner_next = OWN_NONE;
                    end
                    OWN_LSB: if (flush_in || mc_dout_ready) begin
                        state_next = ST_IDLE;
                        owner_next = OWN_NONE;
                    end
                    OWN_ROB: if (!mc_busy) begin
                        state_next    = ST_IDLE;
                        owner_next    = OWN_NONE;
                        rob_done_next = 1'b1;
                    end
                    default: begin
                        state_next = ST_IDLE;
                        owner_next = OWN_NONE;
                    end
                endcase
            end
            default: begin
                state_next = ST_IDLE;
                owner_next = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= OWN_NONE;
            rob_done_reg <= 1'b0;
            starve_reg   <= '0;
        end else if (rdy_in) begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rob_done_reg <= rob_done_next;
            // Counts data grants that overtook a waiting fetch.
            if (!full_reg[SRC_IC] || clear_vec[SRC_IC]) begin
                starve_reg <= '0;
            end else if ((state_reg == ST_ISSUE) && (starve_reg != STARVE_MAX)) begin
                starve_reg <= starve_reg + SW'(1);
            end
        end
    end

    assign ic_ack       = ack_reg[SRC_IC];
    assign lsb_ack      = ack_reg[SRC_LSB];
    assign rob_ack      = ack_reg[SRC_ROB];
    assign rob_done     = rob_done_reg;
    assign mc_ic_valid  = clear_vec[SRC_IC];
    assign mc_lsb_valid = clear_vec[SRC_LSB];
    assign mc_rob_valid = clear_vec[SRC_ROB];
    assign busy_out     = (state_reg != ST_IDLE) || (|full_reg);

    always_comb begin
        mc_addr    = '0;
        mc_din     = '0;
        mc_ld_type = '0;
        mc_st_type = '0;
        mc_dep     = '1;
        case (owner_reg)
            OWN_IC:  mc_addr = ic_addr_reg;
            OWN_LSB: begin
                mc_addr    = lsb_addr_reg;
                mc_ld_type = lsb_type_reg;
                mc_dep     = lsb_dep_reg;
            end
            OWN_ROB: begin
                mc_addr    = rob_addr_reg;
                mc_din     = rob_data_reg;
                mc_st_type = rob_type_reg;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_STATS_EN
    localparam int NUM_STAT = 5;
    logic [NUM_STAT-1:0] stat_inc;
    logic [CNT_W-1:0]    stat_reg [NUM_STAT];

    assign stat_inc[0] = clear_vec[SRC_IC];
    assign stat_inc[1] = clear_vec[SRC_LSB];
    assign stat_inc[2] = clear_vec[SRC_ROB];
    assign stat_inc[3] = (state_reg != ST_IDLE) && (|full_reg);
    assign stat_inc[4] = flush_in && read_owner && (state_reg != ST_IDLE);

    generate
        for (gi = 0; gi < NUM_STAT; gi++) begin : g_stat
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    stat_reg[gi] <= '0;
                end else if (rdy_in && stat_inc[gi] && (stat_reg[gi] != {CNT_W{1'b1}})) begin
                    stat_reg[gi] <= stat_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign stat_ic_grants = stat_reg[0];
    assign stat_ld_grants = stat_reg[1];
    assign stat_st_grants = stat_reg[2];
    assign stat_stall     = stat_reg[3];
    assign stat_killed    = stat_reg[4];
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port byte-serial memory controller between three requesters: instruction fetch (icache), data load (LSB) and committed store (RoB).
- Latches each request, picks one, drives a one-cycle one-hot valid into the controller, and tracks the in-flight owner until completion.
- Routes completion back to the owner, kills speculative reads on flush, and keeps fetch from starving under heavy data traffic.
- Sits between the icache/LSB/RoB and mem_controller.

Parameters:
- ROB_W, 4: RoB index width; dependency tags are ROB_W+1 bits, all-ones = none.
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch waits.
- CNT_W, 32: statistics counter width (optional feature only).

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; when low, all state holds
- flush_in  in  1  misprediction flush
- ic_req  in  1  fetch request; held until ic_ack
- ic_addr  in  32  fetch address
- ic_ack  out  1  one-cycle pulse: fetch request latched
- lsb_req  in  1  load request; held until lsb_ack
- lsb_addr  in  32  load address
- lsb_dep  in  ROB_W+1  load RoB tag
- lsb_type  in  3  load type
- lsb_ack  out  1  one-cycle pulse: load request latched
- rob_req  in  1  store request; held until rob_ack
- rob_addr  in  32  store address
- rob_data  in  32  store data
- rob_type  in  2  store type
- rob_ack  out  1  one-cycle pulse: store request latched
- rob_done  out  1  one-cycle pulse: store finished in memory
- mc_ic_valid, mc_lsb_valid, mc_rob_valid  out  1 each  one-hot valids to the controller
- mc_addr  out  32  muxed address
- mc_din  out  32  store data
- mc_ld_type  out  3  load type
- mc_st_type  out  2  store type
- mc_dep  out  ROB_W+1  load tag
- mc_busy  in  1  controller busy
- mc_dout_ready  in  1  load data ready
- mc_iout_ready  in  1  fetch data ready
- busy_out  out  1  arbiter not IDLE or any slot pending

Behaviour:
- Reset values:
  - All outputs 0, except mc_dep = all-ones.
  - State IDLE, all three pending slots empty, starve counter 0.
- Pending slots: one per source.
  - A request with an empty slot is latched the same cycle and acked on the next edge; ack is a 1-cycle pulse.
  - The requester must drop req the cycle after ack. A new req is accepted only once its slot is empty again.
- States IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - If !mc_busy and any slot is full, select a winner.
  - Default priority: store > load > fetch.
  - If the fetch slot is full and the starve counter equals STARVE_LIMIT, fetch wins.
  - Move to ISSUE and register the owner.
- ISSUE:
  - Exactly one mc_*_valid high for exactly one cycle; address, data and types driven from the winner's slot.
  - Clear the winner's slot; go to WAIT.
  - Starve counter: +1 on a data grant while fetch is pending (saturating); reset to 0 on a fetch grant or when the fetch slot is empty.
- WAIT, leaves to IDLE when:
  - load owner: mc_dout_ready is seen;
  - fetch owner: mc_iout_ready is seen;
  - store owner: mc_busy is low, and rob_done is pulsed the same cycle.
- Back-to-back: the earliest next ISSUE is 1 cycle after returning to IDLE (2-cycle minimum bubble between grants).
- Flush (flush_in high):
  - Clears the load and fetch slots, including same-cycle incoming requests; no ack is issued for them.
  - If the owner is a load or fetch in ISSUE/WAIT: go to IDLE next cycle; the controller aborts itself.
  - Store slot and in-flight store are unaffected.
- Simultaneous flush and a ready for a read owner: flush wins; the ready is ignored downstream.
- rdy_in low: state, slots, counters and outputs all hold; valid pulses are not repeated.
- Reset mid-WAIT: arbiter returns to IDLE; the controller is reset by the same rst_in.

Optional Feature:
- MEM_ARB_STATS_EN.
- Defined: CNT_W counters for grants per source, stall cycles (any slot full while not IDLE) and flush-killed reads. They saturate, clear on reset, and are exposed on extra output ports stat_ic_grants, stat_ld_grants, stat_st_grants, stat_stall, stat_killed.
- Undefined: no counters and no extra ports; the block is otherwise identical.

Decomposition:
- Shared package/include:
  - owner encoding (NONE, IC, LSB, ROB);
  - state encoding;
  - load/store type widths, reusing the existing LOAD/STORE_TYPE_NUM_WIDTH constants.
- One natural sub-module, mem_arb_pick: combinational priority plus starvation override, from slot-full bits and starve count to a one-hot winner.

Test Plan:
- Fetch only: ic_req at 0x1000 -> ic_ack next cycle; mc_ic_valid 1 cycle with mc_addr=0x1000; IDLE after mc_iout_ready.
- Load and store requested in the same cycle -> store issued first; load issued only after rob_done; mc_dep carries the load tag, e.g. 5'b00011.
- Starvation: continuous loads with a pending fetch, STARVE_LIMIT=4 -> fetch granted on the 5th arbitration.
- Flush during load WAIT -> IDLE next cycle, no load completion; a pending fetch slot is cleared.
- Flush during store WAIT -> store completes and rob_done pulses once.
- rdy_in low for 3 cycles during ISSUE -> mc_*_valid held, not duplicated; sequence resumes unchanged.
